// File: rtl/nod_shift_decoder.sv
`default_nettype none
// ============================================================================
// Module   : nod_shift_decoder
// Brief    : Decodes a one-hot NOD code into an exponent and scales an 8-bit
//            operand by 2^exp through a two-stage valid/ready pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module nod_shift_decoder #(
    parameter int ERR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [8:0]       nod_i,
    input  logic             zero_i,
    input  logic [7:0]       operand_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [3:0]       exp_o,
    output logic             zero_o,
    output logic [15:0]      product_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};

    logic             r_s1_valid;
    logic [3:0]       r_s1_exp;
    logic             r_s1_zero;
    logic             r_s1_err;
    logic [7:0]       r_s1_operand;

    logic             r_s2_valid;
    logic [3:0]       r_s2_exp;
    logic             r_s2_zero;
    logic [15:0]      r_s2_product;
    logic             r_s2_err;
    logic [ERR_W-1:0] r_err_count;

    logic             w_s2_free;
    logic             w_in_ready;
    logic             w_accept;
    logic [3:0]       w_hi_bit;
    logic [3:0]       w_popcount;
    logic             w_nod_nz;
    logic             w_zero;
    logic [3:0]       w_exp;
    logic             w_illegal;
    logic [15:0]      w_shifted;

    assign w_s2_free  = ~r_s2_valid | out_ready_i;
    assign w_in_ready = ~rst_i & (~r_s1_valid | w_s2_free);
    assign w_accept   = in_valid_i & w_in_ready;

    // Ascending scan leaves the highest set bit, so illegal multi-hot codes
    // still resolve to a usable exponent.
    always_comb begin
        w_hi_bit   = 4'd0;
        w_popcount = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (nod_i[k]) begin
                w_hi_bit = 4'(k);
            end
            w_popcount = w_popcount + {3'b000, nod_i[k]};
        end
    end

    assign w_nod_nz  = |nod_i;
    assign w_zero    = zero_i | ~w_nod_nz;
    assign w_exp     = w_zero ? 4'd0 : w_hi_bit;
    assign w_illegal = (zero_i & w_nod_nz) | (~zero_i & (w_popcount != 4'd1));
    assign w_shifted = {8'b0, r_s1_operand} << r_s1_exp;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid   <= 1'b0;
            r_s1_exp     <= 4'd0;
            r_s1_zero    <= 1'b0;
            r_s1_err     <= 1'b0;
            r_s1_operand <= 8'd0;
            r_s2_valid   <= 1'b0;
            r_s2_exp     <= 4'd0;
            r_s2_zero    <= 1'b0;
            r_s2_product <= 16'd0;
            r_s2_err     <= 1'b0;
            r_err_count  <= '0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= in_valid_i;
                if (in_valid_i) begin
                    r_s1_exp     <= w_exp;
                    r_s1_zero    <= w_zero;
                    r_s1_err     <= w_illegal;
                    r_s1_operand <= operand_i;
                end
            end
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_exp     <= r_s1_exp;
                    r_s2_zero    <= r_s1_zero;
                    r_s2_product <= r_s1_zero ? 16'd0 : w_shifted;
                    r_s2_err     <= r_s1_err;
                end
            end
            if (w_accept && w_illegal && (r_err_count != c_ERR_MAX)) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_s2_valid;
    assign exp_o       = r_s2_exp;
    assign zero_o      = r_s2_zero;
    assign product_o   = r_s2_product;
    assign err_o       = r_s2_err;
    assign err_count_o = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_nod_shift_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nod_shift_decoder
// Brief    : Directed bench for nod_shift_decoder with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nod_shift_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [8:0]  nod;
    logic        zero_in;
    logic [7:0]  operand;

    logic        in_ready, out_valid, zero_out, err_out;
    logic [3:0]  exp_out;
    logic [15:0] product;
    logic [7:0]  err_count;

    logic        d2_in_ready, d2_out_valid, d2_zero, d2_err;
    logic [3:0]  d2_exp;
    logic [15:0] d2_product;
    logic [1:0]  d2_err_count;

    always #5 clk = ~clk;

    nod_shift_decoder #(.ERR_W(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .nod_i(nod), .zero_i(zero_in), .operand_i(operand),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .exp_o(exp_out),
        .zero_o(zero_out), .product_o(product), .err_o(err_out),
        .err_count_o(err_count)
    );

    nod_shift_decoder #(.ERR_W(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(d2_in_ready),
        .nod_i(nod), .zero_i(zero_in), .operand_i(operand),
        .out_valid_o(d2_out_valid), .out_ready_i(out_ready), .exp_o(d2_exp),
        .zero_o(d2_zero), .product_o(d2_product), .err_o(d2_err),
        .err_count_o(d2_err_count)
    );

    typedef struct {
        int exp;
        int zero;
        int prod;
        int err;
        int acc;
        int avail;
    } beat_t;

    beat_t q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    mcount   = 0;
    int    mcount2  = 0;
    bit    last_acc;

    function automatic beat_t model_beat(input logic [8:0] n, input logic z,
                                         input logic [7:0] o, input int acc);
        beat_t b;
        int hi = 0;
        for (int k = 0; k < 9; k++) if (n[k]) hi = k;
        b.zero  = (z || n == 0) ? 1 : 0;
        b.exp   = b.zero ? 0 : hi;
        b.err   = z ? (n != 0) : ($countones(n) != 1);
        b.prod  = b.zero ? 0 : int'(o) * (1 << b.exp);
        b.acc   = acc;
        b.avail = acc + 2;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [8:0] n,
                        input logic z, input logic [7:0] o, input logic rdy);
        bit    m_ready, m_ov, acc, xfer;
        beat_t b;
        rst = r; in_valid = v; nod = n; zero_in = z; operand = o; out_ready = rdy;
        #1;
        m_ready = !r && (q.size() < 2 || rdy);
        m_ov    = q.size() > 0 && q[0].avail <= cyc;
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("d2_in_ready", 32'(d2_in_ready), 32'(m_ready));
        chk("d2_out_valid", 32'(d2_out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("exp", 32'(exp_out), q[0].exp);
            chk("zero", 32'(zero_out), q[0].zero);
            chk("product", 32'(product), q[0].prod);
            chk("err", 32'(err_out), q[0].err);
            chk("d2_exp", 32'(d2_exp), q[0].exp);
            chk("d2_zero", 32'(d2_zero), q[0].zero);
            chk("d2_product", 32'(d2_product), q[0].prod);
            chk("d2_err", 32'(d2_err), q[0].err);
        end
        chk("err_count", 32'(err_count), mcount);
        chk("d2_err_count", 32'(d2_err_count), mcount2);
        acc  = v && m_ready;
        xfer = m_ov && rdy;
        last_acc = acc;
        @(posedge clk);
        if (r) begin
            q.delete();
            mcount  = 0;
            mcount2 = 0;
        end else begin
            if (xfer) begin
                void'(q.pop_front());
                if (q.size() > 0)
                    q[0].avail = (q[0].acc + 2 > cyc + 1) ? q[0].acc + 2 : cyc + 1;
            end
            if (acc) begin
                b = model_beat(n, z, o, cyc);
                q.push_back(b);
                if (b.err != 0) begin
                    if (mcount < 255) mcount++;
                    if (mcount2 < 3) mcount2++;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 9'h000, 1'b0, 8'd0, rdy);
    endtask

    logic [8:0] bp_nod [4];
    logic [7:0] bp_op  [4];
    int         idx;
    int         budget;

    initial begin
        rst = 1'b1; in_valid = 1'b0; nod = '0; zero_in = 1'b0; operand = '0; out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        step(1'b1, 1'b1, 9'h010, 1'b0, 8'd5, 1'b1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_exp", 32'(exp_out), 0);
        chk("rst_zero", 32'(zero_out), 0);
        chk("rst_product", 32'(product), 0);
        chk("rst_err", 32'(err_out), 0);
        chk("rst_err_count", 32'(err_count), 0);

        // single legal beat, 2-cycle latency
        step(1'b0, 1'b1, 9'h010, 1'b0, 8'd13, 1'b1);
        idle(1'b1);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_exp", 32'(exp_out), 4);
        chk("t1_product", 32'(product), 208);
        idle(1'b1);

        // back-to-back extremes
        step(1'b0, 1'b1, 9'h100, 1'b0, 8'd255, 1'b1);
        step(1'b0, 1'b1, 9'h001, 1'b0, 8'd7, 1'b1);
        chk("t2a_exp", 32'(exp_out), 8);
        chk("t2a_product", 32'(product), 32'hFF00);
        idle(1'b1);
        chk("t2b_exp", 32'(exp_out), 0);
        chk("t2b_product", 32'(product), 7);
        idle(1'b1);

        // zero flag, then implicit zero (illegal)
        step(1'b0, 1'b1, 9'h000, 1'b1, 8'd99, 1'b1);
        step(1'b0, 1'b1, 9'h000, 1'b0, 8'd99, 1'b1);
        chk("t3a_zero", 32'(zero_out), 1);
        chk("t3a_err", 32'(err_out), 0);
        idle(1'b1);
        chk("t3b_zero", 32'(zero_out), 1);
        chk("t3b_err", 32'(err_out), 1);
        chk("t3b_err_count", 32'(err_count), 1);

        // multi-hot illegal code uses highest bit
        step(1'b0, 1'b1, 9'h014, 1'b0, 8'd3, 1'b1);
        idle(1'b1);
        chk("t4_product", 32'(product), 48);
        chk("t4_err_count", 32'(err_count), 2);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 9'h003 << (i % 4), (i == 5), 8'(i + 1), 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("t4_sat2", 32'(d2_err_count), 3);
        chk("t4_count8", 32'(err_count), 8);

        // backpressure: 4 beats offered while downstream stalls
        bp_nod = '{9'h002, 9'h020, 9'h080, 9'h008};
        bp_op  = '{8'd11, 8'd200, 8'd1, 8'd77};
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, idx < 4, bp_nod[idx % 4], 1'b0, bp_op[idx % 4], 1'b0);
            if (last_acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 2);
        chk("bp_hold_product", 32'(product), 22);
        budget = 0;
        while ((idx < 4 || q.size() > 0) && budget < 20) begin
            step(1'b0, idx < 4, bp_nod[idx % 4], 1'b0, bp_op[idx % 4], 1'b1);
            if (last_acc) idx++;
            budget++;
        end
        chk("bp_drain_budget", 32'(budget < 20), 1);

        // toggled downstream readiness
        for (int i = 0; i < 12; i++)
            step(1'b0, (i % 3) != 2, 9'h001 << (i % 9), 1'b0, 8'(17 * i + 3), (i % 2) == 0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // reset with two beats in flight
        step(1'b0, 1'b1, 9'h040, 1'b0, 8'd9, 1'b1);
        step(1'b0, 1'b1, 9'h011, 1'b0, 8'd9, 1'b1);
        step(1'b1, 1'b1, 9'h004, 1'b0, 8'd9, 1'b1);
        chk("rst2_out_valid", 32'(out_valid), 0);
        chk("rst2_err_count", 32'(err_count), 0);
        step(1'b0, 1'b1, 9'h004, 1'b0, 8'd10, 1'b1);
        chk("rst2_gap", 32'(out_valid), 0);
        idle(1'b1);
        chk("rst2_valid", 32'(out_valid), 1);
        chk("rst2_product", 32'(product), 40);
        idle(1'b1);
        idle(1'b1);

        // main counter saturation
        for (int i = 0; i < 260; i++) step(1'b0, 1'b1, 9'h1FF, 1'b0, 8'd1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("sat8", 32'(err_count), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
